// File: rtl/actmem_write_ctrl_pkg.sv
// Shared constants, FSM state type and derived-width helpers for the activation-memory write path.
package actmem_write_ctrl_pkg;

    localparam logic [1:0] TRIT_ZERO = 2'b00;
    localparam logic [1:0] TRIT_POS  = 2'b01;
    localparam logic [1:0] TRIT_NEG  = 2'b11;
    localparam int TRITS_PER_BYTE = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DONE
    } state_e;

    function automatic int eff_trits_per_word(input int n_i, input int weight_stagger);
        return n_i / weight_stagger;
    endfunction

    // Every started group of five trits costs one byte.
    function automatic int phys_bits_per_word(input int eff_trits);
        return ((eff_trits + TRITS_PER_BYTE - 1) / TRITS_PER_BYTE) * 8;
    endfunction

    function automatic int num_banks(input int k, input int weight_stagger);
        return k * weight_stagger;
    endfunction

    function automatic int bank_depth(input int width, input int height, input int k);
        return (width * height + k - 1) / k;
    endfunction

    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/actmem_write_ctrl_enc.sv
// Packs five ternary trits into one base-3 byte: sum of (t_i+1)*3^i, t0 least significant.
module trit_encoder5
    import actmem_write_ctrl_pkg::*;
(
    input  logic [4:0][1:0] trits_i,
    output logic [7:0]      byte_o
);

    // Unused code 2'b10 is treated as a zero trit.
    function automatic logic [7:0] digit(input logic [1:0] code);
        case (code)
            TRIT_POS: return 8'd2;
            TRIT_NEG: return 8'd0;
            default:  return 8'd1;
        endcase
    endfunction

    always_comb begin
        byte_o = digit(trits_i[0])
               + 8'd3  * digit(trits_i[1])
               + 8'd9  * digit(trits_i[2])
               + 8'd27 * digit(trits_i[3])
               + 8'd81 * digit(trits_i[4]);
    end

endmodule

// File: rtl/actmem_write_ctrl.sv
// Streams ternary pixels into the banked activation memory, one registered write per word.
// Optional ACTMEM_WR_PERF_CNT_EN adds the wr_words_o written-word counter.
module actmem_write_ctrl
    import actmem_write_ctrl_pkg::*;
#(
    parameter int N_I            = 512,
    parameter int K              = 3,
    parameter int WEIGHT_STAGGER = 8,
    parameter int IMAGEWIDTH     = 224,
    parameter int IMAGEHEIGHT    = 224,
    localparam int EFFECTIVETRITSPERWORD = eff_trits_per_word(N_I, WEIGHT_STAGGER),
    localparam int PHYSICALBITSPERWORD   = phys_bits_per_word(EFFECTIVETRITSPERWORD),
    localparam int NUMBANKS              = num_banks(K, WEIGHT_STAGGER),
    localparam int BANKDEPTH             = bank_depth(IMAGEWIDTH, IMAGEHEIGHT, K),
    localparam int AW                    = clog2_min1(BANKDEPTH),
    localparam int NPW                   = $clog2(IMAGEWIDTH * IMAGEHEIGHT + 1)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          start_i,
    input  logic [NPW-1:0]                                num_pixels_i,
    input  logic                                          act_valid_i,
    output logic                                          act_ready_o,
    input  logic [0:N_I-1][1:0]                           act_i,
    output logic [0:NUMBANKS-1][PHYSICALBITSPERWORD-1:0]  wdata_o,
    output logic [0:NUMBANKS-1][AW-1:0]                   addr_o,
    output logic [0:NUMBANKS-1]                           write_enable_o,
    output logic                                          busy_o,
    output logic                                          done_o
`ifdef ACTMEM_WR_PERF_CNT_EN
    ,
    output logic [31:0]                                   wr_words_o
`endif
);

    localparam int BYTES_PER_WORD = PHYSICALBITSPERWORD / 8;
    localparam int GW             = clog2_min1(K);

    state_e         state;
    logic [NPW-1:0] num_px;
    logic [NPW-1:0] px_cnt;
    logic [GW-1:0]  grp_cnt;
    logic [AW-1:0]  row_cnt;
    logic           accept;

    logic [WEIGHT_STAGGER-1:0][PHYSICALBITSPERWORD-1:0] enc;

    assign accept = act_valid_i && act_ready_o;

    genvar w, b, j;
    generate
        for (w = 0; w < WEIGHT_STAGGER; w++) begin : g_word
            for (b = 0; b < BYTES_PER_WORD; b++) begin : g_byte
                logic [4:0][1:0] grp;
                for (j = 0; j < TRITS_PER_BYTE; j++) begin : g_trit
                    if (b * TRITS_PER_BYTE + j < EFFECTIVETRITSPERWORD) begin : g_real
                        assign grp[j] = act_i[w * EFFECTIVETRITSPERWORD + b * TRITS_PER_BYTE + j];
                    end else begin : g_pad
                        assign grp[j] = TRIT_ZERO;
                    end
                end
                trit_encoder5 u_enc (
                    .trits_i (grp),
                    .byte_o  (enc[w][b*8 +: 8])
                );
            end
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= ST_IDLE;
            num_px         <= '0;
            px_cnt         <= '0;
            grp_cnt        <= '0;
            row_cnt        <= '0;
            act_ready_o    <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            write_enable_o <= '0;
            wdata_o        <= '0;
            addr_o         <= '0;
        end else begin
            write_enable_o <= '0;
            done_o         <= 1'b0;

            // Only the current bank group is written; other banks keep data and address.
            for (int bk = 0; bk < NUMBANKS; bk++) begin
                if (accept && grp_cnt == GW'(bk / WEIGHT_STAGGER)) begin
                    write_enable_o[bk] <= 1'b1;
                    wdata_o[bk]        <= enc[bk % WEIGHT_STAGGER];
                    addr_o[bk]         <= row_cnt;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        num_px  <= num_pixels_i;
                        px_cnt  <= '0;
                        grp_cnt <= '0;
                        row_cnt <= '0;
                        busy_o  <= 1'b1;
                        if (num_pixels_i == '0) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state       <= ST_STREAM;
                            act_ready_o <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (accept) begin
                        px_cnt <= px_cnt + NPW'(1);
                        if (grp_cnt == GW'(K - 1)) begin
                            grp_cnt <= '0;
                            row_cnt <= row_cnt + AW'(1);
                        end else begin
                            grp_cnt <= grp_cnt + GW'(1);
                        end
                        // Drop ready on the last pixel so no extra pixel slips in.
                        if (px_cnt + NPW'(1) == num_px)
                            act_ready_o <= 1'b0;
                    end else if (px_cnt == num_px) begin
                        state  <= ST_DONE;
                        done_o <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state       <= ST_IDLE;
                    act_ready_o <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

`ifdef ACTMEM_WR_PERF_CNT_EN
    logic [32:0] wr_words_sum;
    assign wr_words_sum = {1'b0, wr_words_o} + 33'($countones(write_enable_o));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            wr_words_o <= '0;
        else if (start_i && state == ST_IDLE)
            wr_words_o <= '0;
        else if (wr_words_sum[32])
            wr_words_o <= 32'hFFFF_FFFF;
        else
            wr_words_o <= wr_words_sum[31:0];
    end
`endif

endmodule

// File: tb/tb_actmem_write_ctrl.sv
// Randomized scoreboard bench for actmem_write_ctrl (N_I=40, K=3, WEIGHT_STAGGER=2).
module tb_actmem_write_ctrl;

    localparam int N_I = 40;
    localparam int K   = 3;
    localparam int WS  = 2;
    localparam int NB  = 6;
    localparam int ETW = 20;
    localparam int AW  = 15;
    localparam int NPW = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [NPW-1:0]         num_pixels = '0;
    logic                   act_valid = 1'b0;
    logic                   act_ready;
    logic [0:N_I-1][1:0]    act = '0;
    logic [0:NB-1][31:0]    wdata;
    logic [0:NB-1][AW-1:0]  addr;
    logic [0:NB-1]          we;
    logic                   busy;
    logic                   done;
`ifdef ACTMEM_WR_PERF_CNT_EN
    logic [31:0]            wr_words;
`endif

    actmem_write_ctrl #(.N_I(N_I), .K(K), .WEIGHT_STAGGER(WS)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .num_pixels_i   (num_pixels),
        .act_valid_i    (act_valid),
        .act_ready_o    (act_ready),
        .act_i          (act),
        .wdata_o        (wdata),
        .addr_o         (addr),
        .write_enable_o (we),
        .busy_o         (busy),
        .done_o         (done)
`ifdef ACTMEM_WR_PERF_CNT_EN
        ,
        .wr_words_o     (wr_words)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          pix;
        int          grp;
        int          addr;
        logic [0:NB-1] mask;
        logic [31:0] d0;
        logic [31:0] d1;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   nstrobe = 0;
    logic [0:N_I-1][1:0] pix [0:15];

    function automatic int trit_val(input logic [1:0] code);
        if (code == 2'b01) return 1;
        if (code == 2'b11) return -1;
        return 0;
    endfunction

    // Base-3 digits (t+1), five trits per byte, lowest trit and byte first.
    function automatic logic [31:0] model_word(input logic [0:N_I-1][1:0] px, input int w);
        logic [31:0] r;
        r = '0;
        for (int by = 0; by < 4; by++) begin
            int v, pw;
            v = 0;
            pw = 1;
            for (int i = 0; i < 5; i++) begin
                v += (trit_val(px[w*ETW + by*5 + i]) + 1) * pw;
                pw *= 3;
            end
            r[by*8 +: 8] = v[7:0];
        end
        return r;
    endfunction

    function automatic logic [0:N_I-1][1:0] mk_pix(input int mode);
        logic [0:N_I-1][1:0] px;
        for (int i = 0; i < N_I; i++) begin
            int t;
            t = (mode == 0) ? int'($urandom_range(0, 2)) - 1 : (mode == 1) ? 0 : (mode == 2) ? 1 : -1;
            px[i] = (t == 1) ? 2'b01 : (t == -1) ? 2'b11 : 2'b00;
        end
        return px;
    endfunction

    task automatic push_exp(input int p);
        exp_t e;
        e.pix  = p;
        e.grp  = p % K;
        e.addr = p / K;
        e.mask = '0;
        e.mask[e.grp*WS]     = 1'b1;
        e.mask[e.grp*WS + 1] = 1'b1;
        e.d0   = model_word(pix[p], 0);
        e.d1   = model_word(pix[p], 1);
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] req_v);
        total++;
        if (act_v !== req_v) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act_v, req_v);
        end
    endtask

    // Monitor: every strobe and every done pulse is matched against the queues.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (we != '0) begin
            nstrobe += $countones(we);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL write: unexpected strobe we=%b at cycle %0d", we, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (we !== e.mask || addr[e.grp*WS] != AW'(e.addr) || addr[e.grp*WS+1] != AW'(e.addr) ||
                    wdata[e.grp*WS] !== e.d0 || wdata[e.grp*WS+1] !== e.d1) begin
                    bad++;
                    $display("FAIL write pix%0d: got we=%b addr=%0d data=%h/%h want we=%b addr=%0d data=%h/%h",
                             e.pix, we, addr[e.grp*WS], wdata[e.grp*WS], wdata[e.grp*WS+1],
                             e.mask, e.addr, e.d0, e.d1);
                end
            end
        end
        if (done) begin
            total++;
            if (done_q.size() == 0) begin
                bad++;
                $display("FAIL done: unexpected pulse at cycle %0d", cyc);
            end else begin
                int d;
                d = done_q.pop_front();
                if (d != cyc) begin
                    bad++;
                    $display("FAIL done: pulse at cycle %0d want %0d", cyc, d);
                end
            end
        end
    end

    // vmode: 0 random valid, 1 valid toggling each cycle, 2 valid always high
    task automatic run_layer(input int n, input int vmode);
        int p, guard, tog;
        @(negedge clk);
        start = 1'b1;
        num_pixels = NPW'(n);
        if (n == 0) done_q.push_back(cyc + 1);
        @(negedge clk);
        start = 1'b0;
        p = 0;
        guard = 0;
        tog = 1;
        while (p < n && guard < 2000) begin
            logic v;
            v = (vmode == 2) ? 1'b1 : (vmode == 1) ? tog[0] : 1'($urandom_range(0, 1));
            tog ^= 1;
            act_valid = v;
            act = pix[p];
            if (v && act_ready) begin
                push_exp(p);
                if (p == n - 1) done_q.push_back(cyc + 2);
                p++;
            end
            @(negedge clk);
            guard++;
        end
        act_valid = 1'b0;
        if (p < n) begin
            total++;
            bad++;
            $display("FAIL layer timeout: accepted %0d want %0d", p, n);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int s0;
        #1;
        check("reset we", 32'(we), 32'h0);
        check("reset ready", 32'(act_ready), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset done", 32'(done), 32'h0);
        check("reset wdata0", wdata[0], 32'h0);
        check("reset addr5", 32'(addr[5]), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single all-zero pixel.
        pix[0] = mk_pix(1);
        run_layer(1, 2);
        check("zero pix wdata0", wdata[0], 32'h79797979);
        check("zero pix wdata1", wdata[1], 32'h79797979);
        check("zero pix addr0", 32'(addr[0]), 32'h0);
        check("idle busy", 32'(busy), 32'h0);

        // Pixels 4 (+1) and 5 (-1) land in groups 1 and 2 at row 1.
        for (int i = 0; i < 4; i++) pix[i] = mk_pix(0);
        pix[4] = mk_pix(2);
        pix[5] = mk_pix(3);
        run_layer(6, 2);
        check("pos wdata2", wdata[2], 32'hF2F2F2F2);
        check("pos wdata3", wdata[3], 32'hF2F2F2F2);
        check("neg wdata4", wdata[4], 32'h0);
        check("neg wdata5", wdata[5], 32'h0);
        check("row1 addr2", 32'(addr[2]), 32'd1);
        check("row1 addr5", 32'(addr[5]), 32'd1);

        // Seven pixels with toggling valid.
        for (int i = 0; i < 7; i++) pix[i] = mk_pix(0);
        s0 = nstrobe;
        run_layer(7, 1);
        check("toggle strobes", 32'(nstrobe - s0), 32'd14);
        check("toggle final addr", 32'(addr[0]), 32'd2);
`ifdef ACTMEM_WR_PERF_CNT_EN
        check("perf count", wr_words, 32'd14);
`endif

        // Empty layer: done only.
        s0 = nstrobe;
        run_layer(0, 2);
        check("empty strobes", 32'(nstrobe - s0), 32'd0);
`ifdef ACTMEM_WR_PERF_CNT_EN
        check("perf cleared", wr_words, 32'd0);
`endif

        // Reset in the acceptance cycle of pixel 2.
        for (int i = 0; i < 5; i++) pix[i] = mk_pix(0);
        @(negedge clk);
        start = 1'b1;
        num_pixels = NPW'(5);
        @(negedge clk);
        start = 1'b0;
        for (int p = 0; p < 2; p++) begin
            check("abort ready", 32'(act_ready), 32'h1);
            act_valid = 1'b1;
            act = pix[p];
            push_exp(p);
            @(negedge clk);
        end
        act = pix[2];
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        act_valid = 1'b0;
        s0 = nstrobe;
        repeat (4) @(negedge clk);
        check("abort strobes", 32'(nstrobe - s0), 32'd0);
        check("abort busy", 32'(busy), 32'h0);
        check("abort ready low", 32'(act_ready), 32'h0);
        pix[0] = mk_pix(0);
        pix[1] = mk_pix(0);
        run_layer(2, 2);
        check("restart addr0", 32'(addr[0]), 32'h0);

        // Random layers.
        for (int l = 0; l < 4; l++) begin
            int n;
            n = int'($urandom_range(1, 12));
            for (int i = 0; i < n; i++) pix[i] = mk_pix(0);
            run_layer(n, 0);
        end

        repeat (3) @(negedge clk);
        check("writes left", 32'(exp_q.size()), 32'd0);
        check("dones left", 32'(done_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
